// File: rtl/fifo_pkg.sv
// Shared types and sizing for the single-port FIFO pop stage and its skid buffer.
// Pointers are sized for the deepest legal skid buffer and wrap at the actual depth.
package fifo_pkg;

  localparam int SKID_DEPTH_MAX = 4;
  localparam int SKID_PTR_W     = $clog2(SKID_DEPTH_MAX);
  localparam int SKID_SLOTS     = 1 << SKID_PTR_W;
  localparam int SKID_OCC_W     = $clog2(SKID_DEPTH_MAX + 1);

  typedef enum logic [1:0] {
    POP_ERR_NONE,
    POP_ERR_UNEXP,
    POP_ERR_OVF,
    POP_ERR_UNF
  } pop_err_cause_e;

  function automatic logic [SKID_PTR_W-1:0] skid_ptr_inc(input logic [SKID_PTR_W-1:0] ptr,
                                                        input int depth);
    return (int'(ptr) == depth - 1) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_skid_buf.sv
// Circular skid buffer: registered storage, wrapping pointers and an occupancy count.
// Read data comes straight from storage so the consumer never sees a path from the FIFO.
module sync_fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [SKID_OCC_W-1:0] occupancy,
  output logic [WIDTH-1:0]      rd_data
);

  localparam logic [SKID_OCC_W-1:0] DEPTH_L = SKID_OCC_W'(SKID_DEPTH);

  logic [WIDTH-1:0]      mem_reg [SKID_SLOTS];
  logic [SKID_PTR_W-1:0] wr_ptr_reg;
  logic [SKID_PTR_W-1:0] rd_ptr_reg;
  logic [SKID_OCC_W-1:0] occ_reg;
  logic [SKID_SLOTS-1:0] wr_en;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (occ_reg == DEPTH_L);
  assign empty   = (occ_reg == '0);
  assign pop_ok  = pop && !empty;
  // A full buffer still accepts a word when one leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  for (genvar gi = 0; gi < SKID_SLOTS; gi++) begin : g_wr_en
    assign wr_en[gi] = push_ok && (wr_ptr_reg == SKID_PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      for (int i = 0; i < SKID_SLOTS; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < SKID_SLOTS; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_data;
      end
      if (push_ok) wr_ptr_reg <= skid_ptr_inc(wr_ptr_reg, SKID_DEPTH);
      if (pop_ok)  rd_ptr_reg <= skid_ptr_inc(rd_ptr_reg, SKID_DEPTH);
      case ({push_ok, pop_ok})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occupancy = occ_reg;
  assign rd_data   = mem_reg[rd_ptr_reg];

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n) occ_reg <= DEPTH_L);

endmodule

// File: rtl/sync_fifo_pop_stage.sv
// Pops a single-port FIFO on credit and replays the words as a valid/ready stream.
// Pops are withheld while empty, while the writer pushes, or when the skid buffer lacks room.
module sync_fifo_pop_stage
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SKID_DEPTH = 2,
  parameter int RD_LAT     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_mt,
  input  logic             fifo_wr,
  output logic             fifo_rd,
  input  logic             fifo_rd_vld,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             pop_err
);

  localparam int INF_W = $clog2(RD_LAT + 1);
  localparam logic [SKID_OCC_W:0] DEPTH_L = (SKID_OCC_W + 1)'(SKID_DEPTH);

  logic [INF_W-1:0]      inflight_reg;
  logic [INF_W-1:0]      drop_cnt_reg;
  pop_err_cause_e        err_cause_reg;
  pop_err_cause_e        err_cause_next;
  logic                  rd_acc;
  logic                  deq;
  logic                  inf_inc;
  logic                  inf_dec;
  logic                  buf_full;
  logic                  buf_empty;
  logic [SKID_OCC_W-1:0] occ;
  logic [SKID_OCC_W:0]   credit_used;

  assign out_vld = !buf_empty;
  assign deq     = out_vld && out_rdy;
  // Read data landing inside the post-reset window belongs to a pop issued before reset.
  assign rd_acc  = fifo_rd_vld && (drop_cnt_reg == '0);

  assign credit_used = {1'b0, occ} + (SKID_OCC_W + 1)'(inflight_reg);
  assign fifo_rd     = reset_n && !fifo_mt && !fifo_wr &&
                       (credit_used < DEPTH_L + {{SKID_OCC_W{1'b0}}, deq});

  assign inf_inc = fifo_rd;
  assign inf_dec = rd_acc && (inflight_reg != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight_reg <= '0;
      drop_cnt_reg <= INF_W'(RD_LAT);
    end else begin
      if (drop_cnt_reg != '0) drop_cnt_reg <= drop_cnt_reg - 1'b1;
      case ({inf_inc, inf_dec})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // The first cause seen is latched for debug; the flag itself is sticky until reset.
  always_comb begin
    err_cause_next = err_cause_reg;
    if (err_cause_reg == POP_ERR_NONE) begin
      if (rd_acc && (inflight_reg == '0))  err_cause_next = POP_ERR_UNEXP;
      else if (rd_acc && buf_full && !deq) err_cause_next = POP_ERR_OVF;
      else if (fifo_rd && fifo_mt)         err_cause_next = POP_ERR_UNF;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_cause_reg <= POP_ERR_NONE;
    else          err_cause_reg <= err_cause_next;
  end

  assign pop_err = (err_cause_reg != POP_ERR_NONE);

  sync_fifo_skid_buf #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_acc),
    .push_data (fifo_dout),
    .pop       (deq),
    .full      (buf_full),
    .empty     (buf_empty),
    .occupancy (occ),
    .rd_data   (out_data)
  );

  a_no_rd_wr:   assert property (@(posedge clk) disable iff (!reset_n) !(fifo_rd && fifo_wr));
  a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
                                 (out_vld && !out_rdy) |=> $stable(out_data));
  a_no_ovf:     assert property (@(posedge clk) disable iff (!reset_n)
                                 !(rd_acc && buf_full && !deq));
  a_no_unf:     assert property (@(posedge clk) disable iff (!reset_n) !(fifo_rd && fifo_mt));

endmodule

// File: tb/tb_sync_fifo_pop_stage.sv
// Bench for sync_fifo_pop_stage: a queue-based FIFO model feeds the DUT and a word-level
// scoreboard predicts pops, stream contents and the error flag every cycle.
module tb_sync_fifo_pop_stage;

  localparam int WIDTH      = 16;
  localparam int SKID_DEPTH = 2;
  localparam int RD_LAT     = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             fifo_mt;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_rd_vld;
  logic [WIDTH-1:0] fifo_dout;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             pop_err;

  always #5 clk = ~clk;

  sync_fifo_pop_stage #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_mt     (fifo_mt),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_dout   (fifo_dout),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .pop_err     (pop_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // FIFO model and word-level scoreboard
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] out_log[$];
  int               inflight_n = 0;
  int               drop_n     = RD_LAT;
  bit               err_m      = 1'b0;
  bit               pend_vld   = 1'b0;
  logic [WIDTH-1:0] pend_data  = '0;
  bit               inject     = 1'b0;
  logic [WIDTH-1:0] inj_data   = '0;
  logic [WIDTH-1:0] next_word  = 16'h0100;

  int ph_cyc, first_rd, first_vld, pops, beats, last_beat, max_gap, rd_wr_clash;

  task automatic start_phase();
    ph_cyc = 0; first_rd = -1; first_vld = -1; pops = 0; beats = 0;
    last_beat = 0; max_gap = 0; rd_wr_clash = 0;
    out_log.delete();
  endtask

  task automatic run_cycle();
    bit               act_rd, deq_m, exp_rd, vld_in;
    logic [WIDTH-1:0] din;
    int               used;
    fifo_mt     = (fifo_q.size() == 0);
    vld_in      = pend_vld || inject;
    din         = inject ? inj_data : pend_data;
    fifo_rd_vld = vld_in;
    fifo_dout   = din;
    @(negedge clk);
    deq_m  = (exp_q.size() != 0) && out_rdy;
    used   = exp_q.size() + inflight_n - int'(deq_m);
    exp_rd = reset_n && !fifo_mt && !fifo_wr && (used < SKID_DEPTH);
    check_eq("fifo_rd", fifo_rd, exp_rd);
    check_eq("out_vld", out_vld, exp_q.size() != 0);
    if (exp_q.size() != 0) check_eq("out_data", out_data, exp_q[0]);
    check_eq("pop_err", pop_err, err_m);
    act_rd = (fifo_rd === 1'b1);
    if (act_rd) begin
      pops++;
      if (first_rd < 0) first_rd = ph_cyc;
      if (fifo_wr) rd_wr_clash++;
    end
    if (out_vld === 1'b1 && first_vld < 0) first_vld = ph_cyc;
    @(posedge clk);
    if (!reset_n) begin
      exp_q.delete();
      inflight_n = 0;
      drop_n     = RD_LAT;
      err_m      = 1'b0;
    end else begin
      if (deq_m) begin
        out_log.push_back(exp_q.pop_front());
        if (beats > 0 && ph_cyc - last_beat > max_gap) max_gap = ph_cyc - last_beat;
        last_beat = ph_cyc;
        beats++;
      end
      if (vld_in && drop_n == 0) begin
        if (inflight_n == 0) err_m = 1'b1;
        else inflight_n--;
        if (exp_q.size() < SKID_DEPTH) exp_q.push_back(din);
      end
      if (drop_n > 0) drop_n--;
      if (act_rd) inflight_n++;
    end
    pend_vld = act_rd;
    if (act_rd) pend_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
    if (fifo_wr) begin
      fifo_q.push_back(next_word);
      next_word++;
    end
    ph_cyc++;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; fifo_wr = 1'b0; out_rdy = 1'b0;
    fifo_mt = 1'b0; fifo_rd_vld = 1'b0; fifo_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fifo_rd", fifo_rd, 1'b0);
    check_eq("rst_out_vld", out_vld, 1'b0);
    check_eq("rst_out_data", out_data, 16'h0000);
    check_eq("rst_pop_err", pop_err, 1'b0);
    reset_n = 1'b1;

    // Full-rate drain of 8 preloaded words
    start_phase();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(WIDTH'(i));
    out_rdy = 1'b1;
    repeat (12) run_cycle();
    check_eq("t1_first_rd", first_rd, 0);
    check_eq("t1_first_vld", first_vld, 2);
    check_eq("t1_beats", beats, 8);
    check_eq("t1_last_beat", last_beat, 9);
    for (int i = 0; i < 8; i++)
      check_eq("t1_order", (i < out_log.size()) ? out_log[i] : 16'hxxxx, WIDTH'(i + 1));

    // Backpressure: two pops fill the skid buffer, then release
    start_phase();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(WIDTH'(16'h10 + i));
    out_rdy = 1'b0;
    repeat (10) run_cycle();
    check_eq("t2_pops", pops, 2);
    check_eq("t2_rd_held", fifo_rd, 1'b0);
    check_eq("t2_held_data", out_data, 16'h0011);
    start_phase();
    out_rdy = 1'b1;
    repeat (12) run_cycle();
    check_eq("t2_beats", beats, 8);
    check_eq("t2_gap_ok", max_gap <= 2, 1'b1);
    for (int i = 0; i < 8; i++)
      check_eq("t2_order", (i < out_log.size()) ? out_log[i] : 16'hxxxx, WIDTH'(16'h11 + i));

    // Writer pushes every other cycle while draining
    start_phase();
    for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'(16'h21 + i));
    next_word = 16'h0100;
    for (int c = 0; c < 24; c++) begin
      fifo_wr = (c < 12) && (c % 2 == 0);
      run_cycle();
    end
    fifo_wr = 1'b0;
    check_eq("t3_rd_wr_clash", rd_wr_clash, 0);
    check_eq("t3_beats", beats, 12);
    for (int i = 0; i < 12; i++)
      check_eq("t3_order", (i < out_log.size()) ? out_log[i] : 16'hxxxx,
               (i < 6) ? WIDTH'(16'h21 + i) : WIDTH'(16'h0100 + i - 6));

    // Single word
    start_phase();
    fifo_q.push_back(16'hBEEF);
    repeat (8) run_cycle();
    check_eq("t4_pops", pops, 1);
    check_eq("t4_beats", beats, 1);
    check_eq("t4_data", (out_log.size() > 0) ? out_log[0] : 16'hxxxx, 16'hBEEF);
    check_eq("t4_rd_idle", fifo_rd, 1'b0);
    check_eq("t4_vld_idle", out_vld, 1'b0);

    // Unexpected read data sets a sticky error, cleared only by reset
    start_phase();
    inject = 1'b1; inj_data = 16'h5A5A;
    run_cycle();
    inject = 1'b0;
    repeat (3) run_cycle();
    check_eq("t5_err_sticky", pop_err, 1'b1);
    reset_n = 1'b0;
    run_cycle();
    check_eq("t5_err_cleared", pop_err, 1'b0);
    check_eq("t5_vld_cleared", out_vld, 1'b0);
    reset_n = 1'b1;

    // Reset with a pop in flight: the stale word never reaches the stream
    start_phase();
    for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'(16'h31 + i));
    run_cycle();
    reset_n = 1'b0;
    run_cycle();
    reset_n = 1'b1;
    start_phase();
    repeat (10) run_cycle();
    check_eq("t6_first_beat", (out_log.size() > 0) ? out_log[0] : 16'hxxxx, 16'h0032);
    check_eq("t6_beats", beats, 3);
    check_eq("t6_pop_err", pop_err, 1'b0);

    // Random pushes, backpressure and occasional resets
    start_phase();
    for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'($urandom));
    repeat (400) begin
      fifo_wr = ($urandom_range(0, 9) < 3);
      out_rdy = ($urandom_range(0, 9) < 6);
      reset_n = ($urandom_range(0, 99) != 0);
      run_cycle();
    end
    reset_n = 1'b1; fifo_wr = 1'b0; out_rdy = 1'b1;
    repeat (260) run_cycle();
    check_eq("rnd_rd_wr_clash", rd_wr_clash, 0);
    check_eq("rnd_drained", out_vld, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
